// File: rtl/tour_cmd_pkg.sv
// Shared types and constants for the knight's-tour command initiator (package tour_pkg).
package tour_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_VERT  = 3'd1,
      S_VWAIT = 3'd2,
      S_HORZ  = 3'd3,
      S_HWAIT = 3'd4
   } state_t;

   localparam int IDX_W = 5;

   localparam logic [3:0] OP_MOVE    = 4'b0100;
   localparam logic [3:0] OP_MOVE_FF = 4'b0101;

   localparam logic [7:0] HDG_N = 8'h00;
   localparam logic [7:0] HDG_W = 8'h3F;
   localparam logic [7:0] HDG_S = 8'h7F;
   localparam logic [7:0] HDG_E = 8'hBF;

   localparam logic [7:0] RESP_DONE  = 8'hA5;
   localparam logic [7:0] RESP_ACK   = 8'h5A;
   localparam logic [7:0] RESP_ABORT = 8'hEE;

   function automatic logic [15:0] make_cmd(input logic [3:0] op,
                                             input logic [7:0] hdg,
                                             input logic [2:0] sq);
      return {op, hdg, 1'b0, sq};
   endfunction

endpackage

// File: rtl/tour_cmd_if.sv
// Command bus between the initiator (master) and the command processor (slave).
interface tour_cmd_if;
   // cmd is valid while cmd_rdy is high and holds until the slave pulses
   // clr_cmd_rdy; the slave later pulses send_resp once the command is done,
   // and resp is meaningful in that send_resp cycle.
   logic [15:0] cmd;
   logic        cmd_rdy;
   logic        clr_cmd_rdy;
   logic        send_resp;
   logic [7:0]  resp;

   modport master (
      output cmd, cmd_rdy, resp,
      input  clr_cmd_rdy, send_resp
   );

   modport slave (
      input  cmd, cmd_rdy, resp,
      output clr_cmd_rdy, send_resp
   );
endinterface

// File: rtl/tour_cmd_knight_move_decode.sv
// Splits a one-hot knight move into a vertical leg and a horizontal leg.
module knight_move_decode
   import tour_pkg::*;
(
   input  logic [7:0] move,
   output logic [7:0] v_hdg,
   output logic [2:0] v_sq,
   output logic [7:0] h_hdg,
   output logic [2:0] h_sq
);

   // Lowest set bit wins; an all-zero move falls through to the bit0 move.
   always_comb begin
      v_hdg = HDG_N;
      v_sq  = 3'd2;
      h_hdg = HDG_W;
      h_sq  = 3'd1;
      casez (move)
         8'b???????1: begin v_hdg = HDG_N; v_sq = 3'd2; h_hdg = HDG_W; h_sq = 3'd1; end
         8'b??????10: begin v_hdg = HDG_N; v_sq = 3'd2; h_hdg = HDG_E; h_sq = 3'd1; end
         8'b?????100: begin v_hdg = HDG_N; v_sq = 3'd1; h_hdg = HDG_W; h_sq = 3'd2; end
         8'b????1000: begin v_hdg = HDG_S; v_sq = 3'd1; h_hdg = HDG_W; h_sq = 3'd2; end
         8'b???10000: begin v_hdg = HDG_S; v_sq = 3'd2; h_hdg = HDG_W; h_sq = 3'd1; end
         8'b??100000: begin v_hdg = HDG_S; v_sq = 3'd2; h_hdg = HDG_E; h_sq = 3'd1; end
         8'b?1000000: begin v_hdg = HDG_S; v_sq = 3'd1; h_hdg = HDG_E; h_sq = 3'd2; end
         8'b10000000: begin v_hdg = HDG_N; v_sq = 3'd1; h_hdg = HDG_E; h_sq = 3'd2; end
         default: ;
      endcase
   end

endmodule

// File: rtl/tour_cmd.sv
// Tour command initiator: forwards UART commands in IDLE, replays the knight's tour otherwise.
// Optional abort of a running tour via UART opcode F when TOUR_CMD_ABORT_EN is defined.
module tour_cmd
   import tour_pkg::*;
#(
   parameter int NUM_MOVES = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_tour,
   input  logic [7:0]       move,
   output logic [IDX_W-1:0] mv_indx,
   input  logic [15:0]      cmd_UART,
   input  logic             cmd_rdy_UART,
   output logic             clr_cmd_rdy_UART,
   tour_cmd_if.master       bus,
   output state_t           state
);

   state_t           state_q, state_next;
   logic [IDX_W-1:0] mv_q, mv_next;
   logic [15:0]      cmd_q, cmd_next;
   logic             rdy_q, rdy_next;
   logic             abort_q, abort_next;
   logic             abort_pulse;
   logic             last;

   logic [7:0] v_hdg, h_hdg;
   logic [2:0] v_sq, h_sq;

   knight_move_decode u_decode (
      .move  (move),
      .v_hdg (v_hdg),
      .v_sq  (v_sq),
      .h_hdg (h_hdg),
      .h_sq  (h_sq)
   );

   assign last = (mv_q == IDX_W'(NUM_MOVES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         mv_q    <= '0;
         cmd_q   <= 16'h0000;
         rdy_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_next;
         mv_q    <= mv_next;
         cmd_q   <= cmd_next;
         rdy_q   <= rdy_next;
         abort_q <= abort_next;
      end
   end

   // The tour command is latched on the first VERT/HORZ cycle (move is read
   // combinationally from mv_indx) and cmd_rdy rises the cycle after, so cmd
   // is already stable whenever cmd_rdy is high.
   always_comb begin
      state_next  = state_q;
      mv_next     = mv_q;
      cmd_next    = cmd_q;
      rdy_next    = rdy_q;
      abort_next  = abort_q;
      abort_pulse = 1'b0;
`ifdef TOUR_CMD_ABORT_EN
      if (state_q != S_IDLE && cmd_rdy_UART && cmd_UART[15:12] == 4'hF && !abort_q) begin
         abort_pulse = 1'b1;
         abort_next  = 1'b1;
      end
`endif
      case (state_q)
         S_IDLE: begin
            if (start_tour) begin
               state_next = S_VERT;
               mv_next    = '0;
            end
         end
         S_VERT: begin
            if (rdy_q && bus.clr_cmd_rdy) begin
               state_next = S_VWAIT;
               rdy_next   = 1'b0;
            end else if (abort_q) begin
               state_next = S_IDLE;
               mv_next    = '0;
               rdy_next   = 1'b0;
            end else if (!rdy_q) begin
               cmd_next = make_cmd(OP_MOVE, v_hdg, v_sq);
               rdy_next = 1'b1;
            end
         end
         S_VWAIT: begin
            if (bus.send_resp) begin
               if (abort_q) begin
                  state_next = S_IDLE;
                  mv_next    = '0;
               end else begin
                  state_next = S_HORZ;
               end
            end
         end
         S_HORZ: begin
            if (rdy_q && bus.clr_cmd_rdy) begin
               state_next = S_HWAIT;
               rdy_next   = 1'b0;
            end else if (abort_q) begin
               state_next = S_IDLE;
               mv_next    = '0;
               rdy_next   = 1'b0;
            end else if (!rdy_q) begin
               cmd_next = make_cmd(OP_MOVE_FF, h_hdg, h_sq);
               rdy_next = 1'b1;
            end
         end
         S_HWAIT: begin
            if (bus.send_resp) begin
               if (abort_q) begin
                  state_next = S_IDLE;
                  mv_next    = '0;
               end else if (last) begin
                  state_next = S_IDLE;
               end else begin
                  state_next = S_VERT;
                  mv_next    = mv_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_next = S_IDLE;
            mv_next    = '0;
            rdy_next   = 1'b0;
         end
      endcase
      if (state_next == S_IDLE) begin
         abort_next = 1'b0;
      end
   end

   always_comb begin
      if (state_q == S_IDLE) begin
         bus.resp = RESP_DONE;
      end else if (abort_q) begin
         bus.resp = RESP_ABORT;
      end else if (state_q == S_HWAIT && last) begin
         bus.resp = RESP_DONE;
      end else begin
         bus.resp = RESP_ACK;
      end
   end

   assign bus.cmd          = (state_q == S_IDLE) ? cmd_UART     : cmd_q;
   assign bus.cmd_rdy      = (state_q == S_IDLE) ? cmd_rdy_UART : rdy_q;
   assign clr_cmd_rdy_UART = (state_q == S_IDLE) ? bus.clr_cmd_rdy : abort_pulse;
   assign mv_indx          = mv_q;
   assign state            = state_q;

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
- Initiator side of the 16-bit cmd / cmd_rdy / clr_cmd_rdy / send_resp interface consumed by the command processor.
- In UART mode it forwards host commands unchanged.
- When a tour starts, it takes over the interface and replays the solved knight's tour: it reads one-hot moves by index and splits each into a vertical move and then a horizontal move.
- It returns a response byte for every completed command.

Parameters:
- NUM_MOVES, 24, number of knight moves in a full tour (5x5 board); width of mv_indx = 5.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_tour  in  1  one-cycle pulse from the tour solver: the tour solution is ready
- move  in  8  one-hot knight move for mv_indx (combinational read)
- mv_indx  out  5  index of the move being executed
- cmd_UART  in  16  command from the UART wrapper
- cmd_rdy_UART  in  1  UART command valid
- clr_cmd_rdy_UART  out  1  consume pulse back to the UART wrapper
- cmd  out  16  command to the command processor
- cmd_rdy  out  1  command valid to the command processor
- clr_cmd_rdy  in  1  command processor accepted cmd
- send_resp  in  1  command processor finished the command
- resp  out  8  response byte to transmit (valid while send_resp is high)

Behaviour:
- Command format:
  - cmd[15:12] opcode: 4'b0100 = move, 4'b0101 = move with fanfare.
  - cmd[11:4] heading: N = 8'h00, W = 8'h3F, S = 8'h7F, E = 8'hBF.
  - cmd[3] = 0; cmd[2:0] = squares.
- Move decode (lowest set bit wins; move == 0 decodes as bit0):
  - b0 N2 W1, b1 N2 E1, b2 W2 N1, b3 W2 S1
  - b4 S2 W1, b5 S2 E1, b6 E2 S1, b7 E2 N1
  - The vertical leg (N/S) is always issued first, as opcode 0100.
  - The horizontal leg (E/W) follows, as opcode 0101 (fanfare).
- States: IDLE, VERT, VWAIT, HORZ, HWAIT.
- IDLE:
  - cmd = cmd_UART, cmd_rdy = cmd_rdy_UART, clr_cmd_rdy_UART = clr_cmd_rdy.
  - start_tour → mv_indx <= 0, go to VERT.
- VERT:
  - cmd = vertical command, registered; cmd_rdy = 1.
  - On clr_cmd_rdy → VWAIT; cmd_rdy drops the following cycle.
- VWAIT:
  - cmd_rdy = 0.
  - On send_resp → HORZ.
- HORZ: same as VERT, but issues the horizontal command.
- HWAIT, on send_resp:
  - If mv_indx == NUM_MOVES-1 → IDLE.
  - Otherwise mv_indx++ → VERT.
- Response byte:
  - resp = 8'hA5 in IDLE, and on the final HWAIT send_resp.
  - resp = 8'h5A for every other tour-mode send_resp.
- Handshake rules:
  - cmd is stable for as long as cmd_rdy is high.
  - cmd_rdy is never re-asserted before the send_resp of the previous command.
- clr_cmd_rdy_UART is forced to 0 outside IDLE.
- A UART command arriving mid-tour stays pending; it is serviced after the return to IDLE.
- start_tour outside IDLE is ignored.
- clr_cmd_rdy and send_resp in the same cycle, in VERT or HORZ: clr_cmd_rdy is honoured and send_resp is ignored.
- Reset (at any time) forces: IDLE, mv_indx = 0, cmd_rdy = 0, clr_cmd_rdy_UART = 0, cmd = 16'h0000 (registered tour cmd), resp = 8'hA5.

Optional Feature:
- Macro: TOUR_CMD_ABORT_EN.
- Defined:
  - In any non-IDLE state, cmd_rdy_UART with cmd_UART[15:12] = 4'hF pulses clr_cmd_rdy_UART for one cycle and sets a pending abort.
  - The abort takes effect at the next send_resp, or immediately if in VERT or HORZ before clr_cmd_rdy.
  - Effect: → IDLE, mv_indx = 0, and the resp for that send_resp is 8'hEE.
- Undefined: opcode F is not special; the UART command waits until IDLE.

Decomposition:
- Package tour_pkg:
  - state enum
  - opcode constants OP_MOVE, OP_MOVE_FF
  - heading constants HDG_N/W/S/E
  - response constants RESP_DONE = 8'hA5, RESP_ACK = 8'h5A, RESP_ABORT = 8'hEE
- Sub-module: knight_move_decode (combinational: move → vertical/horizontal heading and squares).
- The FSM stays in tour_cmd.

Test Plan:
- UART pass-through: cmd_UART = 16'h2000, cmd_rdy_UART = 1 in IDLE → cmd = 16'h2000, cmd_rdy = 1; clr_cmd_rdy pulse → clr_cmd_rdy_UART pulse in the same cycle; send_resp → resp = 8'hA5.
- Single move, move = 8'h02 (N2 E1):
  - Issues 16'h4002; hold clr_cmd_rdy low for 10 cycles → cmd and cmd_rdy stable.
  - Then clr_cmd_rdy, send_resp → resp 5A.
  - Then issues 16'h5BF1.
- Full tour with 24 scripted moves → 48 commands in V,H order; mv_indx steps 0..23; 47 responses 5A, final A5; return to IDLE.
- A UART command asserted mid-tour → not forwarded and not cleared until IDLE, then forwarded.
- Reset mid-tour (in VWAIT, mv_indx = 7) → IDLE, mv_indx = 0, cmd_rdy = 0; a new start_tour restarts at index 0.
- With TOUR_CMD_ABORT_EN, UART 16'hF000 during HWAIT → next send_resp gives resp EE, IDLE, mv_indx = 0.
